// File: rtl/cpu_run_ctrl_if.sv
// Front-panel / CPU-side signal bundle for the run-control stage.
// The master side drives the divided clock, buttons and halt; the slave side returns the CPU advance controls.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             clk_slow;
  logic             btn_go;
  logic             btn_step;
  logic             halt;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output clk_slow, btn_go, btn_step, halt,
    input  cpu_en, state, step_cnt
  );

  modport slave (
    input  clk_slow, btn_go, btn_step, halt,
    output cpu_en, state, step_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step/halt control producing a one-clock CPU advance enable.
// It uses the divided clock clk_slow and debounced front-panel buttons, all in the clk domain.
module cpu_run_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_run_ctrl_if.slave bus
);

  localparam int                DEB_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Button index 0 is go, index 1 is step.
  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       level;
  logic [1:0]       level_d;
  logic [1:0]       press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic             slow_q;
  logic             rise;
  logic             go_press;
  logic             step_press;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic             cpu_en_q;
  logic             cpu_en_nxt;
  logic [CNT_W-1:0] step_cnt_q;

  assign raw = {bus.btn_step, bus.btn_go};

  // Stage p0/p1: synchronizer, then debounce; press is registered one clock after the accepted rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      level      <= '0;
      level_d    <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign go_press   = press[0];
  assign step_press = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= bus.clk_slow;
    end
  end

  assign rise = bus.clk_slow & ~slow_q;

  // Halt outranks everything and is sticky; go toggles between pause and run.
  always_comb begin
    state_nxt = state_q;
    if (bus.halt) begin
      state_nxt = ST_HALT;
    end else begin
      case (state_q)
        ST_PAUSE: if (go_press) state_nxt = ST_RUN;
        ST_RUN:   if (go_press) state_nxt = ST_PAUSE;
        ST_HALT:  state_nxt = ST_HALT;
        default:  state_nxt = ST_PAUSE;
      endcase
    end
  end

  // A step coinciding with go in pause is dropped so the transition to run wins.
  always_comb begin
    cpu_en_nxt = !bus.halt &&
                 (((state_q == ST_RUN) && rise) ||
                  ((state_q == ST_PAUSE) && step_press && !go_press));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSE;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt;
      cpu_en_q   <= cpu_en_nxt;
      step_cnt_q <= step_cnt_q + CNT_W'(cpu_en_q);
    end
  end

  assign bus.cpu_en   = cpu_en_q;
  assign bus.state    = state_q;
  assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized buttons, halt, resets and clk_slow rates,
// with every cycle compared against a history-based reference model.
module tb_cpu_run_ctrl;

  localparam int DEB   = 4;
  localparam int CNT_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // clk_slow source: toggles every slow_half clocks, synchronous to clk.
  logic slow_r      = 1'b0;
  bit   slow_rose   = 1'b0;
  bit   slow_freeze = 1'b0;
  int   slow_half   = 5;
  int   slow_cnt    = 0;
  assign bus.clk_slow = slow_r;

  always @(negedge clk) begin
    slow_rose = 1'b0;
    if (slow_freeze) begin
      slow_r   = 1'b0;
      slow_cnt = 0;
    end else if (slow_cnt >= slow_half - 1) begin
      slow_cnt  = 0;
      slow_r    = ~slow_r;
      slow_rose = slow_r;
    end else begin
      slow_cnt++;
    end
  end

  // Reference model: a button level flips once the synchronized value has disagreed with it
  // for the last DEB clocks; a press is seen two clocks after the level rises.
  bit m_sq   [2][DEB];
  bit m_rawp [2];
  bit m_lvl  [2][3];
  int m_st;
  bit m_en;
  int m_cnt;
  bit m_slowp;

  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEB; i++) m_sq[b][i] = 1'b0;
      for (int i = 0; i < 3; i++) m_lvl[b][i] = 1'b0;
      m_rawp[b] = 1'b0;
    end
    m_st = 0; m_en = 1'b0; m_cnt = 0; m_slowp = 1'b0;
  endtask

  task automatic m_step();
    bit raw [2];
    bit prs [2];
    bit rise, new_en, all_diff;
    raw[0] = bus.btn_go;
    raw[1] = bus.btn_step;
    for (int b = 0; b < 2; b++) prs[b] = m_lvl[b][1] & ~m_lvl[b][2];
    rise   = slow_r & ~m_slowp;
    new_en = !bus.halt && ((m_st == 1 && rise) || (m_st == 0 && prs[1] && !prs[0]));
    m_cnt  = (m_cnt + int'(m_en)) % (1 << CNT_W);
    if (bus.halt || m_st == 2) m_st = 2;
    else if (prs[0])           m_st = (m_st == 0) ? 1 : 0;
    m_en    = new_en;
    m_slowp = slow_r;
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (m_sq[b][i] == m_lvl[b][0]) all_diff = 1'b0;
      m_lvl[b][2] = m_lvl[b][1];
      m_lvl[b][1] = m_lvl[b][0];
      m_lvl[b][0] = all_diff ? ~m_lvl[b][0] : m_lvl[b][0];
      for (int i = 0; i < DEB - 1; i++) m_sq[b][i] = m_sq[b][i+1];
      m_sq[b][DEB-1] = m_rawp[b];
      m_rawp[b] = raw[b];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check_val("model_cpu_en",   bus.cpu_en,   m_en);
      check_val("model_state",    bus.state,    m_st);
      check_val("model_step_cnt", bus.step_cnt, m_cnt);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  int pulses;

  // Holds the chosen buttons for 6 clocks, then releases for 8, counting cpu_en pulses.
  task automatic press_btn(input bit go, input bit step);
    bus.btn_go = go; bus.btn_step = step;
    for (int i = 0; i < 6; i++) begin tick(); pulses += int'(bus.cpu_en); end
    bus.btn_go = 1'b0; bus.btn_step = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); pulses += int'(bus.cpu_en); end
  endtask

  int  bad, sc, waited;
  bit  prev_rose;

  initial begin
    bus.btn_go = 1'b0; bus.btn_step = 1'b0; bus.halt = 1'b0;
    tick(3);
    chk_on = 1'b1;
    rst_n = 1'b1;
    tick(2);
    check_val("reset_cpu_en",   bus.cpu_en,   0);
    check_val("reset_state",    bus.state,    0);
    check_val("reset_step_cnt", bus.step_cnt, 0);

    // Single step: held 10 clocks, one pulse after edge 7.
    bus.btn_step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("step_edge%0d", k), bus.cpu_en, (k == 7));
    end
    bus.btn_step = 1'b0;
    tick(10);
    check_val("step_cnt_after_step", bus.step_cnt, 1);
    check_val("step_state",          bus.state,    0);

    // Bounce shorter than the debounce window is rejected.
    for (int r = 0; r < 4; r++) begin
      bus.btn_go = 1'b1; tick(3);
      bus.btn_go = 1'b0; tick(2);
    end
    tick(4);
    check_val("bounce_state", bus.state, 0);
    bus.btn_go = 1'b1; tick(6);
    bus.btn_go = 1'b0; tick(8);
    check_val("go_to_run", bus.state, 1);

    // Run: one pulse per clk_slow period, one clock after each rise.
    sc = int'(bus.step_cnt); pulses = 0; bad = 0; prev_rose = slow_rose;
    for (int i = 0; i < 100; i++) begin
      tick();
      pulses += int'(bus.cpu_en);
      if (bus.cpu_en != prev_rose) bad++;
      prev_rose = slow_rose;
    end
    check_val("run_pulses",   pulses, 10);
    check_val("run_align",    bad, 0);
    check_val("run_step_cnt", (int'(bus.step_cnt) - sc + 256) % 256, 10);
    press_btn(1'b1, 1'b0);
    check_val("run_to_pause", bus.state, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin tick(); pulses += int'(bus.cpu_en); end
    check_val("pause_no_pulse", pulses, 0);

    // Halt coinciding with a rise while running.
    press_btn(1'b1, 1'b0);
    check_val("rerun_state", bus.state, 1);
    waited = 0;
    while (!slow_rose && waited < 40) begin tick(); waited++; end
    check_val("halt_wait_timeout", (waited >= 40), 0);
    bus.halt = 1'b1;
    tick();
    check_val("halt_no_pulse", bus.cpu_en, 0);
    check_val("halt_state",    bus.state,  2);
    sc = int'(bus.step_cnt);
    bus.halt = 1'b0;
    pulses = 0;
    press_btn(1'b1, 1'b0);
    press_btn(1'b0, 1'b1);
    check_val("halt_sticky",   bus.state,    2);
    check_val("halt_frozen",   bus.step_cnt, sc);
    check_val("halt_pulses",   pulses,       0);

    // Counter wrap through single steps, then go/step priority.
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    check_val("rst2_state", bus.state, 0);
    press_btn(1'b1, 1'b0);
    waited = 0;
    while (bus.step_cnt != 8'd254 && waited < 4000) begin tick(); waited++; end
    check_val("wrap_wait_timeout", (waited >= 4000), 0);
    slow_freeze = 1'b1;
    press_btn(1'b1, 1'b0);
    check_val("wrap_pause", bus.state, 0);
    press_btn(1'b0, 1'b1);
    check_val("wrap_max", bus.step_cnt, 255);
    press_btn(1'b0, 1'b1);
    check_val("wrap_zero", bus.step_cnt, 0);
    pulses = 0;
    press_btn(1'b1, 1'b1);
    check_val("prio_state",  bus.state, 1);
    check_val("prio_pulses", pulses,    0);

    // Asynchronous reset mid-run with cpu_en high; go held through reset.
    slow_freeze = 1'b0;
    waited = 0;
    while (!bus.cpu_en && waited < 40) begin tick(); waited++; end
    check_val("mid_wait_timeout", (waited >= 40), 0);
    bus.btn_go = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("async_cpu_en",   bus.cpu_en,   0);
    check_val("async_state",    bus.state,    0);
    check_val("async_step_cnt", bus.step_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_pause", bus.state, 0);
    tick(10);
    check_val("held_go_accepted", bus.state, 1);
    bus.btn_go = 1'b0;
    tick(10);

    // Randomized operation with occasional resets, halts and rate changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.btn_go   = ~bus.btn_go;
      if ($urandom_range(0, 9) == 0) bus.btn_step = ~bus.btn_step;
      bus.halt = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 149) == 0) slow_half = $urandom_range(1, 7);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
